// File: rtl/game_flow_ctrl.sv
// Frame-synchronous START/MENU/GAME/PAUSE/OVER sequencer for the VGA screen selector.
// Decodes PS/2 make events, commits screen changes on frame start, gates movement, runs the game timer.
//   state   | meaning
//   S_START | title screen, waits for ENTER
//   S_MENU  | menu, ENTER starts a fresh game, ESC back to title
//   S_GAME  | play, timer running while unblanked
//   S_PAUSE | play frozen, timer held
//   S_OVER  | time expired, ENTER back to menu
module game_flow_ctrl #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int TIME_LIMIT     = 99,
    parameter int BLANK_FRAMES   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_keycode,
    input  logic        i_vsync,
    input  logic        i_move_up,
    input  logic        i_move_down,
    input  logic        i_move_right,
    input  logic        i_move_left,
    output logic [2:0]  o_screen,
    output logic        o_blank,
    output logic        o_move_up_g,
    output logic        o_move_down_g,
    output logic        o_move_right_g,
    output logic        o_move_left_g,
    output logic [9:0]  o_time_s
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_MENU  = 3'd1,
        S_GAME  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int BC_W = $clog2(BLANK_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_MAX  = FC_W'(FRAMES_PER_SEC - 1);
    localparam logic [9:0]      T_LIM   = 10'(TIME_LIMIT);
    localparam logic [BC_W-1:0] BC_LOAD = BC_W'(BLANK_FRAMES);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_ESC   = 8'h76;
    localparam logic [7:0] K_P     = 8'h4D;

    state_t          r_state;
    state_t          r_pend;
    state_t          w_state_nxt;
    state_t          w_req_tgt;
    logic            w_req_v;
    logic            w_apply;
    logic            w_frame_start;
    logic            w_key_evt;
    logic [15:0]     r_prev_kc;
    logic            r_key_evt;
    logic [7:0]      r_key;
    logic            r_vsync;
    logic            r_vsync_d;
    logic            r_pend_v;
    logic            r_blank;
    logic [BC_W-1:0] r_blank_cnt;
    logic [FC_W-1:0] r_fc;
    logic [9:0]      r_time;
    logic [3:0]      r_move_g;

    assign w_key_evt     = (i_keycode != r_prev_kc) && (i_keycode[15:8] != 8'hF0);
    assign w_frame_start = r_vsync & ~r_vsync_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_kc <= 16'h0000;
            r_key_evt <= 1'b0;
            r_key     <= 8'h00;
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_prev_kc <= i_keycode;
            r_key_evt <= w_key_evt;
            r_key     <= i_keycode[7:0];
            r_vsync   <= i_vsync;
            r_vsync_d <= r_vsync;
        end
    end

    // Legal key -> requested target for the current screen; anything else yields no request.
    always_comb begin
        w_req_v   = 1'b0;
        w_req_tgt = r_state;
        if (r_key_evt) begin
            case (r_state)
                S_START: if (r_key == K_ENTER) begin w_req_v = 1'b1; w_req_tgt = S_MENU; end
                S_MENU: begin
                    if (r_key == K_ENTER)    begin w_req_v = 1'b1; w_req_tgt = S_GAME;  end
                    else if (r_key == K_ESC) begin w_req_v = 1'b1; w_req_tgt = S_START; end
                end
                S_GAME: begin
                    if (r_key == K_P)        begin w_req_v = 1'b1; w_req_tgt = S_PAUSE; end
                    else if (r_key == K_ESC) begin w_req_v = 1'b1; w_req_tgt = S_MENU;  end
                end
                S_PAUSE: begin
                    if (r_key == K_P)        begin w_req_v = 1'b1; w_req_tgt = S_GAME;  end
                    else if (r_key == K_ESC) begin w_req_v = 1'b1; w_req_tgt = S_MENU;  end
                end
                S_OVER: if (r_key == K_ENTER) begin w_req_v = 1'b1; w_req_tgt = S_MENU; end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_apply     = 1'b0;
        w_state_nxt = r_state;
        if (w_frame_start && !r_blank) begin
            if (r_state == S_GAME && r_time == T_LIM) begin
                w_apply     = 1'b1;
                w_state_nxt = S_OVER;
            end else if (r_pend_v) begin
                w_apply     = 1'b1;
                w_state_nxt = r_pend;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_START;
        else       r_state <= w_state_nxt;
    end

    // A capture in the same cycle as an applied change survives for the next frame start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend      <= S_START;
            r_pend_v    <= 1'b0;
            r_blank     <= 1'b0;
            r_blank_cnt <= '0;
            r_fc        <= '0;
            r_time      <= 10'd0;
            r_move_g    <= 4'b0000;
        end else begin
            if (w_req_v && !r_blank) begin
                r_pend   <= w_req_tgt;
                r_pend_v <= 1'b1;
            end else if (w_apply) begin
                r_pend_v <= 1'b0;
            end

            if (w_frame_start) begin
                if (w_apply) begin
                    r_blank     <= 1'b1;
                    r_blank_cnt <= BC_LOAD;
                end else if (r_blank) begin
                    r_blank_cnt <= r_blank_cnt - 1'b1;
                    if (r_blank_cnt == BC_ONE) r_blank <= 1'b0;
                end

                if (w_apply && r_state == S_MENU && w_state_nxt == S_GAME) begin
                    r_fc   <= '0;
                    r_time <= 10'd0;
                end else if (r_state == S_GAME && !r_blank) begin
                    if (r_fc == FC_MAX) begin
                        r_fc <= '0;
                        if (r_time < T_LIM) r_time <= r_time + 10'd1;
                    end else begin
                        r_fc <= r_fc + 1'b1;
                    end
                end
            end

            r_move_g <= {i_move_up, i_move_down, i_move_right, i_move_left}
                        & {4{(r_state == S_GAME) && !r_blank}};
        end
    end

    assign o_screen       = r_state;
    assign o_blank        = r_blank;
    assign o_time_s       = r_time;
    assign o_move_up_g    = r_move_g[3];
    assign o_move_down_g  = r_move_g[2];
    assign o_move_right_g = r_move_g[1];
    assign o_move_left_g  = r_move_g[0];

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Frame-synchronous game-flow controller that sequences the screen shown by the VGA screen-selection path. It decodes PS/2 make events from the 16-bit keycode, runs the START/MENU/GAME/PAUSE/OVER state machine, and commits screen changes only at frame start. It also gates player movement requests and runs the in-game seconds timer. It sits between the keyboard front end and the VGA screen-selection path, and is clocked from the pixel clock domain.

## Interface
Parameters:
- FRAMES_PER_SEC, 60, frame_start pulses per timer second
- TIME_LIMIT, 99, game length in seconds; 10-bit value
- BLANK_FRAMES, 2, frames of forced blank after every screen change; must be ≥1

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- keycode  in  16  PS/2 set-2 bytes: [15:8] previous byte, [7:0] latest byte
- vsync  in  1  vertical sync from the timing interface; active-high
- move_up, move_down, move_right, move_left  in  1 each  raw movement requests
- screen  out  3  0=START, 1=MENU, 2=GAME, 3=PAUSE, 4=OVER
- blank  out  1  high while the screen selector must output black
- move_up_g, move_down_g, move_right_g, move_left_g  out  1 each  gated movement
- time_s  out  10  elapsed game seconds

## Operation
- Key detect
  - prev_kc registers keycode each cycle.
  - key_evt = (keycode != prev_kc) && (keycode[15:8] != 8'hF0).
  - Typematic repeats produce no event. Break codes produce no event.
  - Keys: ENTER=8'h5A, ESC=8'h76, P=8'h4D. Any other key is ignored.
- Frame start: frame_start is a 1-cycle pulse on the rising edge of registered vsync.
- Requests
  - A legal key_evt with blank low writes target state to pend and sets pend_v. A later legal event overwrites pend, so the last key wins.
  - key_evt while blank is high is discarded.
  - Keys not legal in the current state are ignored.
- Transitions, applied only on frame_start:
  - START: ENTER→MENU.
  - MENU: ENTER→GAME, which clears time_s and the frame counter; ESC→START.
  - GAME: P→PAUSE; ESC→MENU; time_s==TIME_LIMIT→OVER. Timeout has priority over pend.
  - PAUSE: P→GAME, keeping time_s; ESC→MENU.
  - OVER: ENTER→MENU.
- On an applied transition:
  - The state updates and pend_v clears.
  - blank goes high, and blank_cnt loads BLANK_FRAMES.
  - blank_cnt decrements on each subsequent frame_start. blank drops on the frame_start at which blank_cnt reaches 0.
- Timer
  - The frame counter counts frame_start only while state==GAME and blank low. It wraps at FRAMES_PER_SEC-1.
  - On wrap, time_s increments, saturating at TIME_LIMIT.
  - In PAUSE, OVER and MENU the timer is frozen.
- Gating: each move_*_g = move_* & (state==GAME) & ~blank, registered.

## Timing
- Reset values:
  - screen=0 (START), blank=0, all move_*_g=0, time_s=0.
  - pend_v=0, prev_kc=16'h0000, blank_cnt=0, frame counter=0, vsync register=0.
- key_evt is asserted in the cycle after keycode changes. pend is valid 1 cycle later.
- frame_start is asserted 1 cycle after the first clk edge that samples vsync high.
- screen, blank and time_s are all registered. They change on the clk edge at which frame_start is high, and are visible the following cycle.
- move_*_g lag move_* by 1 cycle.
- A key_evt in the same cycle as frame_start is captured and applied at the next frame_start. It does not use the current one.
- Reset asserted mid-operation returns every output to its reset value asynchronously. The pending request is lost.
- time_s never exceeds TIME_LIMIT. The frame counter never exceeds FRAMES_PER_SEC-1.

## Test plan
- Reset, then keycode=16'h005A, then one vsync pulse → screen 0→1 one cycle after frame_start; blank=1 for 2 frames, then 0.
- In START: keycode 16'h005A→16'hF05A→16'h005A, with no vsync in between → single pend only; after one frame_start, screen=1.
- In GAME, blank=0, move_left=1 → move_left_g=1 after 1 cycle. Press P (16'h004D) plus one frame → screen=3 and move_left_g=0.
- GAME with FRAMES_PER_SEC=4 and TIME_LIMIT=3 → time_s reaches 3 after 12 unblanked frames; the next frame_start gives screen=4. A P pressed in that frame is ignored.
- ESC (16'h0076) pressed while blank=1 → no transition after blank ends.
- Assert rst asynchronously mid-GAME with pend_v=1 → screen=0, time_s=0, blank=0 with no clock edge. The next frame_start makes no change.
